// File: rtl/utopia_rx_cell_collector.sv
// UTOPIA Level 1 Rx cell collector: en/clav handshake, two-slot cell buffer,
// soc alignment + optional HEC check (`UTOPIA_HEC_CHECK_EN), valid/ready byte stream out.
module utopia_rx_cell_collector #(
  parameter int CELL_BYTES = 53,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_clav,
  output logic             rx_en,
  input  logic             rx_soc,
  input  logic [7:0]       rx_data,
  output logic [7:0]       cell_data,
  output logic             cell_sop,
  output logic             cell_eop,
  output logic             cell_valid,
  input  logic             cell_ready,
  output logic [CNT_W-1:0] hec_err_count,
  output logic [CNT_W-1:0] sync_err_count
);
  localparam int IDX_W = $clog2(CELL_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_XFER   = 2'd1;
  localparam logic [1:0] S_LAST   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] en_cnt_q, en_cnt_d;
  logic [IDX_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             rx_en_q, rx_en_d;
  logic             cap_q, cap_d;
  logic [1:0]       full_q, full_d;
  logic             wr_slot_q, wr_slot_d;
  logic             rd_slot_q, rd_slot_d;
  logic             sync_bad_q, sync_bad_d;
  logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;

  logic [7:0] slot_mem [2][CELL_BYTES];

  logic soc_err, cell_good, commit, rd_fire, rd_eop;

  // cap_q: the byte on rx_data now belongs to an enable issued last cycle
  assign soc_err = cap_q && ((byte_cnt_q == '0) ? !rx_soc : rx_soc);
  assign commit  = (state_q == S_COMMIT);

`ifdef UTOPIA_HEC_CHECK_EN
  localparam logic [IDX_W-1:0] HEC_IDX = IDX_W'(4);

  logic [7:0]       crc_q, crc_d;
  logic             hec_bad_q, hec_bad_d;
  logic [CNT_W-1:0] hec_cnt_q, hec_cnt_d;
  logic             hec_mis;

  // CRC-8, poly x^8+x^2+x+1, MSB first
  function automatic logic [7:0] crc8_byte(input logic [7:0] c);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  assign hec_mis = cap_q && (byte_cnt_q == HEC_IDX) && (rx_data != (crc_q ^ 8'h55));

  always_comb begin
    crc_d     = crc_q;
    hec_bad_d = hec_bad_q | hec_mis;
    hec_cnt_d = hec_cnt_q;
    if (state_q == S_IDLE) begin
      crc_d     = 8'h00;
      hec_bad_d = 1'b0;
    end else if (cap_q && (byte_cnt_q < HEC_IDX)) begin
      crc_d = crc8_byte(crc_q ^ rx_data);
    end
    // sync error takes priority: one count per bad cell
    if (commit && !sync_bad_q && hec_bad_q && (hec_cnt_q != CNT_MAX))
      hec_cnt_d = hec_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q     <= 8'h00;
      hec_bad_q <= 1'b0;
      hec_cnt_q <= '0;
    end else begin
      crc_q     <= crc_d;
      hec_bad_q <= hec_bad_d;
      hec_cnt_q <= hec_cnt_d;
    end
  end

  assign cell_good     = !sync_bad_q && !hec_bad_q;
  assign hec_err_count = hec_cnt_q;
`else
  assign cell_good     = !sync_bad_q;
  assign hec_err_count = '0;
`endif

  assign rd_fire = full_q[rd_slot_q] && cell_ready;
  assign rd_eop  = rd_fire && (rd_cnt_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    en_cnt_d   = en_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    full_d     = full_q;
    wr_slot_d  = wr_slot_q;
    rd_slot_d  = rd_slot_q;
    sync_cnt_d = sync_cnt_q;
    sync_bad_d = sync_bad_q | soc_err;

    case (state_q)
      S_IDLE: begin
        en_cnt_d   = '0;
        byte_cnt_d = '0;
        sync_bad_d = 1'b0;
        if (rx_clav && !full_q[wr_slot_q])
          state_d = S_XFER;
      end
      S_XFER: begin
        en_cnt_d = en_cnt_q + 1'b1;
        if (en_cnt_q == LAST_IDX)
          state_d = S_LAST;
      end
      S_LAST:  state_d = S_COMMIT;
      default: state_d = S_IDLE;
    endcase

    if (cap_q)
      byte_cnt_d = byte_cnt_q + 1'b1;

    if (commit && cell_good) begin
      full_d[wr_slot_q] = 1'b1;
      wr_slot_d         = ~wr_slot_q;
    end
    if (commit && sync_bad_q && (sync_cnt_q != CNT_MAX))
      sync_cnt_d = sync_cnt_q + 1'b1;

    // the slot being read is never the one being committed, so both updates can land together
    if (rd_eop) begin
      full_d[rd_slot_q] = 1'b0;
      rd_slot_d         = ~rd_slot_q;
      rd_cnt_d          = '0;
    end else if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end

    rx_en_d = (state_d != S_XFER);
    cap_d   = !rx_en_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      en_cnt_q   <= '0;
      byte_cnt_q <= '0;
      rd_cnt_q   <= '0;
      rx_en_q    <= 1'b1;
      cap_q      <= 1'b0;
      full_q     <= 2'b00;
      wr_slot_q  <= 1'b0;
      rd_slot_q  <= 1'b0;
      sync_bad_q <= 1'b0;
      sync_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      en_cnt_q   <= en_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      rx_en_q    <= rx_en_d;
      cap_q      <= cap_d;
      full_q     <= full_d;
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      sync_bad_q <= sync_bad_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  // cell storage: plain RAM, contents only matter once a slot is marked full
  always_ff @(posedge clk) begin
    if (!rst && cap_q)
      slot_mem[wr_slot_q][byte_cnt_q] <= rx_data;
  end

  assign rx_en          = rx_en_q;
  assign cell_valid     = full_q[rd_slot_q];
  assign cell_data      = slot_mem[rd_slot_q][rd_cnt_q];
  assign cell_sop       = (rd_cnt_q == '0);
  assign cell_eop       = (rd_cnt_q == LAST_IDX);
  assign sync_err_count = sync_cnt_q;

endmodule

// File: doc/utopia_rx_cell_collector.md
# utopia_rx_cell_collector

Receive-side front end for one UTOPIA Level 1 port of the quad ATM switch (`squat`), sitting between a PHY's Rx UTOPIA signals and the cell forwarding logic. Each instance:
- drives the cell-level `en`/`clav` handshake;
- collects 53-byte UNI cells into a two-slot cell buffer;
- checks header alignment and HEC;
- presents good cells downstream as a byte stream with valid/ready flow control.

One instance is built per Rx port (`NumRx` copies).

## Interface
Parameters:
- `CELL_BYTES`, 53: bytes per cell; header is bytes 0–4, HEC is byte 4.
- `CNT_W`, 8: width of the saturating error counters.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_clav` in 1: PHY cell available.
- `rx_en` out 1: active-low read enable to PHY.
- `rx_soc` in 1: start of cell, valid the cycle after `rx_en`=0.
- `rx_data` in 8: cell byte, valid the cycle after `rx_en`=0.
- `cell_data` out 8: output byte.
- `cell_sop` out 1: marks byte 0 of the output cell.
- `cell_eop` out 1: marks byte 52 of the output cell.
- `cell_valid` out 1: output byte valid.
- `cell_ready` in 1: downstream accepts the byte.
- `hec_err_count` out CNT_W: cells dropped for bad HEC.
- `sync_err_count` out CNT_W: cells dropped for `soc` misalignment.

## Operation
Buffer:
- Two slots of 53 bytes each, with `full[1:0]`, `wr_slot` and `rd_slot` (1-bit, toggling).

Receive FSM:
- **IDLE**
  - `rx_en`=1.
  - Go to XFER when `rx_clav`=1 and `full[wr_slot]`=0.
- **XFER**
  - `rx_en`=0 for exactly 53 consecutive cycles (enable counter 0..52), then go to LAST.
  - Each cycle after an `rx_en`=0 cycle, write `rx_data` to `wr_slot[byte_cnt]` and increment `byte_cnt`.
- **LAST**
  - `rx_en`=1; capture the 53rd byte, then go to COMMIT.
- **COMMIT** (one cycle), then back to IDLE:
  - If the cell is good: set `full[wr_slot]` and toggle `wr_slot`.
  - Otherwise: discard the cell and leave `wr_slot` unchanged.

Checks, evaluated per byte:
- **Sync:** byte 0 must have `rx_soc`=1, and bytes 1–52 must have `rx_soc`=0. Any violation marks the cell bad and increments `sync_err_count`, once per cell. The FSM still completes all 53 enables; the cell is not resynchronised mid-transfer.
- **HEC:**
  - Running CRC-8 over bytes 0–3 with polynomial x^8+x^2+x+1, initial value 0x00.
  - Expected byte 4 = CRC XOR 0x55.
  - A mismatch marks the cell bad and increments `hec_err_count`, unless the cell already has a sync error (sync takes priority; one count per cell).

Output stream:
- `cell_valid` = `full[rd_slot]`.
- `cell_data` = `slot[rd_slot][rd_cnt]`.
- `cell_sop` = (`rd_cnt`==0); `cell_eop` = (`rd_cnt`==52).
- On `cell_valid`&&`cell_ready`, `rd_cnt` increments.
- On the eop handshake: clear `full[rd_slot]`, toggle `rd_slot`, reset `rd_cnt` to 0.
- While `cell_valid`=1 and `cell_ready`=0, data and markers hold.

Counters saturate at 2^CNT_W−1 and clear only on reset.

## Timing
Reset values:
- `rx_en`=1
- `cell_valid`=0 (so `cell_sop`/`cell_eop` are don't-care)
- both counters 0
- all pointers, `byte_cnt` and `full` = 0
- FSM in IDLE

Cycle-level timing:
- `rx_en` falls the cycle after IDLE sees `rx_clav`=1 with a free slot.
- The cell occupies 56 cycles from the IDLE decision to COMMIT; the next XFER can start the cycle after COMMIT.
- `cell_valid` rises the cycle after COMMIT.
- Minimum output time is 53 cycles per cell at `cell_ready`=1.

Boundary cases:
- **Both slots full:** IDLE holds `rx_en`=1 regardless of `rx_clav`.
- **Eop release and COMMIT in the same cycle:** both take effect; the freed slot is usable by the next IDLE decision.
- **`rx_clav` drops during XFER:** ignored; all 53 enables are issued.
- **Reset mid-cell:** the partial cell is discarded, `rx_en`=1 the next cycle, and a cell being streamed out is abandoned (`cell_valid`=0).

## Configuration
- `UTOPIA_HEC_CHECK_EN` defined:
  - HEC check active as above.
  - `hec_err_count` counts bad cells.
- `UTOPIA_HEC_CHECK_EN` undefined:
  - No CRC logic.
  - Cells with correct `soc` alignment are committed regardless of byte 4.
  - `hec_err_count` is tied to 0.
  - Sync checking is unchanged.

## Test plan
- **Good cell:** `rx_clav`=1, cell header 00 00 00 00 55 plus 48 bytes 0x01..0x30 -> exactly 53 `rx_en`-low cycles; output bytes match with sop on 0x00 and eop on 0x30; both counters stay 0.
- **Idle-cell HEC:** header 00 00 00 01 52 -> accepted. Header 00 00 00 01 53 -> dropped, `hec_err_count`=1, `cell_valid` never rises. With `UTOPIA_HEC_CHECK_EN` undefined, both cells are delivered.
- **Misalignment:** `rx_soc`=0 on byte 0, or `rx_soc`=1 on byte 10 -> cell dropped, `sync_err_count` increments by 1 per cell, `hec_err_count` unchanged even if the HEC is also wrong.
- **Backpressure:** `cell_ready`=0 and three cells offered -> two cells buffered, then `rx_en` held at 1 while `rx_clav`=1. Raising `cell_ready` -> 53 bytes out, then a third transfer starts within 2 cycles of the eop handshake.
- **Stall mid-output:** toggle `cell_ready` every cycle -> every byte delivered once, in order, and data holds during stalls.
- **Reset mid-transfer:** assert `rst` at byte 20 -> next cycle `rx_en`=1, counters 0, no output. The next full cell after reset is delivered intact.
